// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-OpenRAM bridge.
// Holds the FSM encoding, default window decode and byte-lane merge.
package wb_sram_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h3000_0000;
    localparam logic [31:0] ADDR_MASK_DEF = 32'hFFFF_F000;
    localparam int          LANES         = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        RMW_WAIT,
        RMW_CAP,
        WR_DONE,
        ACK
    } state_t;

    // Lanes with sel set take the new byte, others keep the SRAM byte.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_sram_ctrl_if.sv
// Wishbone classic slave bundle between the Caravel bus and the SRAM bridge.
// Signal names follow the bus-side port names of the bridge.
interface wb_sram_ctrl_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving one 32x1024 OpenRAM single-port macro.
// Partial writes are done as read-modify-write since the macro has no mask.
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
    parameter logic [31:0] ADDR_MASK  = ADDR_MASK_DEF,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rstn_i,
    wb_sram_ctrl_if.slave         wb,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    state_t                state_q, state_n;
    logic                  ack_q, ack_n;
    logic [31:0]           dat_q, dat_n;
    logic                  csb_q, csb_n;
    logic                  web_q, web_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] din_q, din_n;
    logic                  hit;
    logic                  req;

    assign hit = ((wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign req = wb.wbs_cyc_i & wb.wbs_stb_i & hit & ~ack_q;

    always_comb begin
        state_n = state_q;
        ack_n   = 1'b0;
        dat_n   = dat_q;
        csb_n   = 1'b1;
        web_n   = 1'b1;
        addr_n  = addr_q;
        din_n   = din_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!wb.wbs_we_i) begin
                        csb_n   = 1'b0;
                        addr_n  = wb.wbs_adr_i[ADDR_WIDTH+1:2];
                        state_n = RD_WAIT;
                    end else if (wb.wbs_sel_i == 4'hF) begin
                        csb_n   = 1'b0;
                        web_n   = 1'b0;
                        addr_n  = wb.wbs_adr_i[ADDR_WIDTH+1:2];
                        din_n   = wb.wbs_dat_i;
                        state_n = WR_DONE;
                    end else if (wb.wbs_sel_i == 4'h0) begin
                        state_n = ACK;
                    end else begin
                        csb_n   = 1'b0;
                        addr_n  = wb.wbs_adr_i[ADDR_WIDTH+1:2];
                        state_n = RMW_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_n = wb.wbs_cyc_i ? RD_CAP : IDLE;
            end
            RD_CAP: begin
                // dout0 is stable from the previous negedge through this edge
                if (wb.wbs_cyc_i) begin
                    dat_n = sram_dout0;
                    ack_n = 1'b1;
                end
                state_n = IDLE;
            end
            RMW_WAIT: begin
                state_n = wb.wbs_cyc_i ? RMW_CAP : IDLE;
            end
            RMW_CAP: begin
                if (wb.wbs_cyc_i) begin
                    csb_n   = 1'b0;
                    web_n   = 1'b0;
                    din_n   = byte_merge(sram_dout0,
                                         wb.wbs_dat_i,
                                         wb.wbs_sel_i);
                    state_n = WR_DONE;
                end else begin
                    state_n = IDLE;
                end
            end
            WR_DONE: begin
                ack_n   = wb.wbs_cyc_i;
                state_n = IDLE;
            end
            ACK: begin
                ack_n   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_n;
            ack_q   <= ack_n;
            dat_q   <= dat_n;
            csb_q   <= csb_n;
            web_q   <= web_n;
            addr_q  <= addr_n;
            din_q   <= din_n;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign sram_csb0    = csb_q;
    assign sram_web0    = web_q;
    assign sram_addr0   = addr_q;
    assign sram_din0    = din_q;

endmodule
